sram_march_bist: RTL and testbench

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/sram_bist_pkg.sv | 71 +++++++
 rtl/sram_bist_seq.sv | 78 +++++++
 rtl/sram_march_bist.sv | 216 +++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared encodings for the March C- SRAM BIST: march elements, controller states
// and the per-element operation table.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ELEM_M0 = 3'd0,
        ELEM_M1 = 3'd1,
        ELEM_M2 = 3'd2,
        ELEM_M3 = 3'd3,
        ELEM_M4 = 3'd4,
        ELEM_M5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    typedef struct packed {
        logic write;
        logic one;
    } march_op_t;

    function automatic logic [1:0] elem_ops(input march_elem_e e);
        case (e)
            ELEM_M0, ELEM_M5:                   elem_ops = 2'd1;
            ELEM_M1, ELEM_M2, ELEM_M3, ELEM_M4: elem_ops = 2'd2;
            default:                            elem_ops = 2'd1;
        endcase
    endfunction

    function automatic logic elem_down(input march_elem_e e);
        case (e)
            ELEM_M3, ELEM_M4: elem_down = 1'b1;
            default:          elem_down = 1'b0;
        endcase
    endfunction

    // Phase 0 is the first operation of an element, phase 1 the second.
    function automatic march_op_t elem_op(input march_elem_e e, input logic phase);
        march_op_t op;
        op.write = 1'b0;
        op.one   = 1'b0;
        case (e)
            ELEM_M0: begin
                op.write = 1'b1;
                op.one   = 1'b0;
            end
            ELEM_M1, ELEM_M3: begin
                op.write = phase;
                op.one   = phase;
            end
            ELEM_M2, ELEM_M4: begin
                op.write = phase;
                op.one   = ~phase;
            end
            ELEM_M5: begin
                op.write = 1'b0;
                op.one   = 1'b0;
            end
            default: begin
                op.write = 1'b0;
                op.one   = 1'b0;
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sram_bist_seq.sv
// March C- sequencer: walks element, address and in-element phase, presenting the
// operation at the current position and stepping one operation per advance.
module sram_bist_seq
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output march_elem_e           elem,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  op_write,
    output logic                  op_one,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    march_elem_e           elem_r, elem_s, elem_inc_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  phase_r, phase_s;
    logic                  last_s, addr_end_s;
    march_op_t             op_s;

    assign op_s       = elem_op(elem_r, phase_r);
    assign last_s     = (elem_r == ELEM_M5) && (addr_r == ADDR_MAX);
    assign addr_end_s = elem_down(elem_r) ? (addr_r == {ADDR_WIDTH{1'b0}}) : (addr_r == ADDR_MAX);
    assign elem_inc_s = march_elem_e'(elem_r + 3'd1);

    assign elem     = elem_r;
    assign addr     = addr_r;
    assign op_write = op_s.write;
    assign op_one   = op_s.one;
    assign last     = last_s;

    // Next position: second phase, next address, or first address of the next element.
    always_comb begin
        elem_s  = elem_r;
        addr_s  = addr_r;
        phase_s = phase_r;
        if (advance) begin
            if (last_s) begin
                elem_s  = ELEM_M0;
                addr_s  = {ADDR_WIDTH{1'b0}};
                phase_s = 1'b0;
            end else if ((phase_r == 1'b0) && (elem_ops(elem_r) == 2'd2)) begin
                phase_s = 1'b1;
            end else begin
                phase_s = 1'b0;
                if (addr_end_s) begin
                    elem_s = elem_inc_s;
                    addr_s = elem_down(elem_inc_s) ? ADDR_MAX : {ADDR_WIDTH{1'b0}};
                end else if (elem_down(elem_r)) begin
                    addr_s = addr_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            phase_s = phase_r;
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_r  <= ELEM_M0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            phase_r <= 1'b0;
        end else begin
            elem_r  <= elem_s;
            addr_r  <= addr_s;
            phase_r <= phase_s;
        end
    end

endmodule

// File: rtl/sram_march_bist.sv
// March C- SRAM BIST controller: run FSM, registered SRAM port, read-compare
// pipeline and error/status reporting.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 33,
    parameter int WMASK_WIDTH = 4,
    parameter int RD_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   bg_inv,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic                   sram_spare_wen,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_count,
    output logic [ADDR_WIDTH-1:0]  err_addr,
    output logic [2:0]             err_elem
);

    localparam int DRAIN_W = $clog2(RD_LAT + 1) + 1;

    bist_state_e           state_r, state_s;
    logic                  accept_s, issue_s, last_done_r;
    logic                  bg_inv_r, bg_sel_s;
    logic [DRAIN_W-1:0]    drain_cnt_r;
    march_elem_e           seq_elem_s;
    logic [ADDR_WIDTH-1:0] seq_addr_s;
    logic                  seq_write_s, seq_one_s, seq_last_s;
    logic [DATA_WIDTH-1:0] op_word_s;
    logic                  rd_act_r;
    logic [DATA_WIDTH-1:0] exp_r;
    logic [2:0]            op_elem_r;
    logic [DATA_WIDTH-1:0] pipe_exp_r  [RD_LAT];
    logic [ADDR_WIDTH-1:0] pipe_addr_r [RD_LAT];
    logic [2:0]            pipe_elem_r [RD_LAT];
    logic                  pipe_vld_r  [RD_LAT];
    logic                  mismatch_s;
    logic [7:0]            err_count_s;
    logic [ADDR_WIDTH-1:0] err_addr_s;
    logic [2:0]            err_elem_s;

    sram_bist_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .advance  (issue_s),
        .elem     (seq_elem_s),
        .addr     (seq_addr_s),
        .op_write (seq_write_s),
        .op_one   (seq_one_s),
        .last     (seq_last_s)
    );

    assign issue_s   = accept_s || ((state_r == ST_RUN) && !last_done_r);
    assign op_word_s = seq_one_s ? ~{DATA_WIDTH{bg_sel_s}} : {DATA_WIDTH{bg_sel_s}};
    assign mismatch_s = pipe_vld_r[RD_LAT-1] && (sram_dout != pipe_exp_r[RD_LAT-1]);

    // Next state; the accepting edge already issues the first write using the live bg_inv.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        bg_sel_s = bg_inv_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                    bg_sel_s = bg_inv;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_done_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_W'(RD_LAT)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Error bookkeeping: saturating count, first-failure location frozen per run.
    always_comb begin
        err_count_s = err_count;
        err_addr_s  = err_addr;
        err_elem_s  = err_elem;
        if (accept_s) begin
            err_count_s = 8'd0;
            err_addr_s  = {ADDR_WIDTH{1'b0}};
            err_elem_s  = 3'd0;
        end else if (mismatch_s) begin
            if (err_count != 8'd255) begin
                err_count_s = err_count + 8'd1;
            end else begin
                err_count_s = err_count;
            end
            if (err_count == 8'd0) begin
                err_addr_s = pipe_addr_r[RD_LAT-1];
                err_elem_s = pipe_elem_r[RD_LAT-1];
            end else begin
                err_addr_s = err_addr;
                err_elem_s = err_elem;
            end
        end else begin
            err_count_s = err_count;
        end
    end

    // Control registers: state, end-of-issue flag, drain counter, captured background.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_done_r <= 1'b0;
            drain_cnt_r <= {DRAIN_W{1'b0}};
            bg_inv_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                last_done_r <= 1'b0;
            end else if (issue_s && seq_last_s) begin
                last_done_r <= 1'b1;
            end
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + {{(DRAIN_W-1){1'b0}}, 1'b1}
                                                 : {DRAIN_W{1'b0}};
            if (accept_s) begin
                bg_inv_r <= bg_inv;
            end
        end
    end

    // Registered SRAM port plus the expected word travelling with each read.
    always_ff @(posedge clk) begin
        if (rst || !issue_s) begin
            sram_csb       <= 1'b1;
            sram_web       <= 1'b1;
            sram_wmask     <= {WMASK_WIDTH{1'b0}};
            sram_spare_wen <= 1'b0;
            sram_addr      <= {ADDR_WIDTH{1'b0}};
            sram_din       <= {DATA_WIDTH{1'b0}};
            rd_act_r       <= 1'b0;
            exp_r          <= {DATA_WIDTH{1'b0}};
            op_elem_r      <= 3'd0;
        end else begin
            sram_csb       <= 1'b0;
            sram_web       <= ~seq_write_s;
            sram_wmask     <= seq_write_s ? {WMASK_WIDTH{1'b1}} : {WMASK_WIDTH{1'b0}};
            sram_spare_wen <= seq_write_s;
            sram_addr      <= seq_addr_s;
            sram_din       <= seq_write_s ? op_word_s : {DATA_WIDTH{1'b0}};
            rd_act_r       <= ~seq_write_s;
            exp_r          <= seq_write_s ? {DATA_WIDTH{1'b0}} : op_word_s;
            op_elem_r      <= seq_elem_s;
        end
    end

    // Compare pipeline: stage 0 loads as the SRAM samples a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_exp_r[i]  <= {DATA_WIDTH{1'b0}};
                pipe_addr_r[i] <= {ADDR_WIDTH{1'b0}};
                pipe_elem_r[i] <= 3'd0;
                pipe_vld_r[i]  <= 1'b0;
            end
        end else begin
            pipe_exp_r[0]  <= exp_r;
            pipe_addr_r[0] <= sram_addr;
            pipe_elem_r[0] <= op_elem_r;
            pipe_vld_r[0]  <= rd_act_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_exp_r[i]  <= pipe_exp_r[i-1];
                pipe_addr_r[i] <= pipe_addr_r[i-1];
                pipe_elem_r[i] <= pipe_elem_r[i-1];
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
            end
        end
    end

    // Status and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            err_addr  <= {ADDR_WIDTH{1'b0}};
            err_elem  <= 3'd0;
        end else begin
            busy      <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done      <= (state_s == ST_DONE);
            pass      <= (state_s == ST_DONE) && (err_count_s == 8'd0);
            err_count <= err_count_s;
            err_addr  <= err_addr_s;
            err_elem  <= err_elem_s;
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with a behavioural SRAM that can model a
// stuck-at bit or a tied-off output bus.
module tb_sram_march_bist;

    logic        clk = 1'b0;
    logic        rst, start, bg_inv;
    logic        sram_csb, sram_web, sram_spare_wen;
    logic [3:0]  sram_wmask;
    logic [5:0]  sram_addr;
    logic [32:0] sram_din, sram_dout;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [5:0]  err_addr;
    logic [2:0]  err_elem;

    logic [32:0] mem [64];
    logic [32:0] rdata_r;
    int          fault_mode = 0;
    int          op_total = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    sram_march_bist dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bg_inv         (bg_inv),
        .sram_csb       (sram_csb),
        .sram_web       (sram_web),
        .sram_wmask     (sram_wmask),
        .sram_spare_wen (sram_spare_wen),
        .sram_addr      (sram_addr),
        .sram_din       (sram_din),
        .sram_dout      (sram_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .err_addr       (err_addr),
        .err_elem       (err_elem)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM; fault 1 forces bit 5 of address 17 high on reads.
    always @(posedge clk) begin
        if (!sram_csb) begin
            op_total <= op_total + 1;
            if (!sram_web) begin
                mem[sram_addr] <= sram_din;
            end else begin
                rdata_r <= mem[sram_addr];
                if (fault_mode == 1 && sram_addr == 6'd17) rdata_r[5] <= 1'b1;
            end
        end
    end

    assign sram_dout = (fault_mode == 2) ? 33'h0_0000_0001 : rdata_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic inv);
        @(negedge clk);
        bg_inv = inv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_done(input string tag);
        while (!done && cyc < 2000) step();
        check(tag, 64'(cyc), 64'd642);
    endtask

    initial begin
        int ops0;
        int bad;
        rst = 1'b1; start = 1'b0; bg_inv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_errcnt", 64'(err_count), 64'd0);
        check("rst_csb", 64'(sram_csb), 64'd1);
        check("rst_web", 64'(sram_web), 64'd1);
        rst = 1'b0;
        repeat (2) step();
        check("idle_csb", 64'(sram_csb), 64'd1);

        // Clean run, background 0.
        ops0 = op_total;
        do_start(1'b0);
        check("run_busy", 64'(busy), 64'd1);
        check("m0_first_csb", 64'(sram_csb), 64'd0);
        check("m0_first_web", 64'(sram_web), 64'd0);
        check("m0_first_wmask", 64'(sram_wmask), 64'hF);
        check("m0_first_spare", 64'(sram_spare_wen), 64'd1);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== 6'(i) || sram_din !== 33'h0) bad++;
            step();
        end
        check("m0_writes_bg0", 64'(bad), 64'd0);
        check("m1_rd_web", 64'(sram_web), 64'd1);
        check("m1_rd_addr", 64'(sram_addr), 64'd0);
        check("m1_rd_wmask", 64'(sram_wmask), 64'd0);
        check("m1_rd_spare", 64'(sram_spare_wen), 64'd0);
        step();
        check("m1_wr_web", 64'(sram_web), 64'd0);
        check("m1_wr_din", 64'(sram_din), 64'h1_FFFF_FFFF);
        wait_done("clean_latency");
        check("clean_pass", 64'(pass), 64'd1);
        check("clean_errcnt", 64'(err_count), 64'd0);
        check("clean_busy", 64'(busy), 64'd0);
        check("clean_ops", 64'(op_total - ops0), 64'd640);
        check("clean_csb_after", 64'(sram_csb), 64'd1);

        // Stuck-at-1 on bit 5 of address 17.
        fault_mode = 1;
        do_start(1'b0);
        wait_done("stuck_latency");
        check("stuck_errcnt", 64'(err_count), 64'd3);
        check("stuck_erraddr", 64'(err_addr), 64'd17);
        check("stuck_errelem", 64'(err_elem), 64'd1);
        check("stuck_pass", 64'(pass), 64'd0);

        // Inverted background on a clean array, restarted from DONE.
        fault_mode = 0;
        do_start(1'b1);
        check("restart_errcnt_clr", 64'(err_count), 64'd0);
        check("restart_erraddr_clr", 64'(err_addr), 64'd0);
        check("restart_done_clr", 64'(done), 64'd0);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (sram_web !== 1'b0 || sram_addr !== 6'(i) || sram_din !== 33'h1_FFFF_FFFF) bad++;
            step();
        end
        check("m0_writes_bg1", 64'(bad), 64'd0);
        wait_done("inv_latency");
        check("inv_pass", 64'(pass), 64'd1);

        // Output bus tied to 1: every read fails.
        fault_mode = 2;
        do_start(1'b0);
        wait_done("tied_latency");
        check("tied_errcnt_sat", 64'(err_count), 64'd255);
        check("tied_erraddr", 64'(err_addr), 64'd0);
        check("tied_errelem", 64'(err_elem), 64'd1);
        check("tied_pass", 64'(pass), 64'd0);

        // Start re-pulse mid-run is ignored; reset aborts the run.
        do_start(1'b0);
        while (cyc < 99) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 299) step();
        check("repulse_addr", 64'(sram_addr), 64'd53);
        check("repulse_web", 64'(sram_web), 64'd0);
        check("repulse_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_csb", 64'(sram_csb), 64'd1);
        check("abort_web", 64'(sram_web), 64'd1);
        check("abort_errcnt", 64'(err_count), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        ops0 = op_total;
        repeat (20) step();
        check("abort_no_ops", 64'(op_total - ops0), 64'd0);
        check("abort_errcnt_hold", 64'(err_count), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
